// File: rtl/dual_issue_queue.sv
// In-order dual-issue queue between decode and the even/odd SPU pipes.
// Define DUAL_ISSUE_RAW_CHECK_EN to block pairing on an intra-pair RAW hazard.
module dual_issue_queue #(
    parameter int DEPTH = 8,
    parameter int OP_W  = 8,
    parameter int RA_W  = 7,
    parameter int IMM_W = 18,
    parameter logic [OP_W-1:0] NOP_OP  = OP_W'(1),
    parameter logic [OP_W-1:0] LNOP_OP = OP_W'(2),
    localparam int E_W = 1 + OP_W + 4*RA_W + IMM_W,
    localparam int CW  = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push0_en,
    input  logic             push1_en,
    input  logic [E_W-1:0]   push0_data,
    input  logic [E_W-1:0]   push1_data,
    output logic             ready0,
    output logic             ready1,
    output logic [CW-1:0]    count,
    input  logic             stall,
    input  logic             branch_taken,
    output logic             valid_even,
    output logic [OP_W-1:0]  opcode_even,
    output logic [RA_W-1:0]  addr_ra_even,
    output logic [RA_W-1:0]  addr_rb_even,
    output logic [RA_W-1:0]  addr_rc_even,
    output logic [RA_W-1:0]  addr_rt_even,
    output logic [IMM_W-1:0] imm_even,
    output logic             valid_odd,
    output logic [OP_W-1:0]  opcode_odd,
    output logic [RA_W-1:0]  addr_ra_odd,
    output logic [RA_W-1:0]  addr_rb_odd,
    output logic [RA_W-1:0]  addr_rc_odd,
    output logic [RA_W-1:0]  addr_rt_odd,
    output logic [IMM_W-1:0] imm_odd,
    output logic             br_first_instr
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic             pipe;
        logic [OP_W-1:0]  op;
        logic [RA_W-1:0]  rt;
        logic [RA_W-1:0]  ra;
        logic [RA_W-1:0]  rb;
        logic [RA_W-1:0]  rc;
        logic [IMM_W-1:0] imm;
    } entry_t;

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [RA_W-1:0]  rt;
        logic [RA_W-1:0]  ra;
        logic [RA_W-1:0]  rb;
        logic [RA_W-1:0]  rc;
        logic [IMM_W-1:0] imm;
    } slot_t;

    function automatic slot_t to_slot(input entry_t e);
        slot_t s;
        s.valid = 1'b1;
        s.op    = e.op;
        s.rt    = e.rt;
        s.ra    = e.ra;
        s.rb    = e.rb;
        s.rc    = e.rc;
        s.imm   = e.imm;
        return s;
    endfunction

    function automatic slot_t empty_slot(input logic [OP_W-1:0] op);
        slot_t s;
        s     = '0;
        s.op  = op;
        return s;
    endfunction

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [PW-1:0]   head_p1, tail_p1;
    entry_t          h, n;
    entry_t          in0, in1;
    logic            raw;
    logic            issue_h, issue_n;
    logic            acc0, acc1;
    logic [1:0]      num_issue, num_push;
    logic [CW-1:0]   count_nxt;
    slot_t           even_q, odd_q, even_nxt, odd_nxt;
    logic            br_nxt;

    assign head_p1 = head + PW'(1);
    assign tail_p1 = tail + PW'(1);
    assign h   = mem[head];
    assign n   = mem[head_p1];
    assign in0 = entry_t'(push0_data);
    assign in1 = entry_t'(push1_data);

`ifdef DUAL_ISSUE_RAW_CHECK_EN
    assign raw = (h.rt != '0) && ((h.rt == n.ra) || (h.rt == n.rb) || (h.rt == n.rc));
`else
    assign raw = 1'b0;
`endif

    // Handshake: a slot is accepted when its enable and its pre-edge ready
    // are both high at the rising edge; slot 1 also needs slot 0 accepted.
    // A flush drops both slots.
    always_comb begin
        acc0      = push0_en && ready0 && !branch_taken;
        acc1      = acc0 && push1_en && ready1;
        issue_h   = !stall && !branch_taken && (count != '0);
        issue_n   = issue_h && (count >= CW'(2)) && (n.pipe != h.pipe) && !raw;
        num_issue = {1'b0, issue_h} + {1'b0, issue_n};
        num_push  = {1'b0, acc0} + {1'b0, acc1};
        count_nxt = count + CW'(num_push) - CW'(num_issue);
    end

    // H goes to its own pipe; a paired N takes the other one.
    always_comb begin
        even_nxt = empty_slot(NOP_OP);
        odd_nxt  = empty_slot(LNOP_OP);
        br_nxt   = 1'b0;
        if (issue_h) begin
            if (h.pipe) odd_nxt  = to_slot(h);
            else        even_nxt = to_slot(h);
        end
        if (issue_n) begin
            if (h.pipe) even_nxt = to_slot(n);
            else        odd_nxt  = to_slot(n);
            br_nxt = h.pipe;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ready0         <= 1'b1;
            ready1         <= 1'b1;
            even_q         <= empty_slot(NOP_OP);
            odd_q          <= empty_slot(LNOP_OP);
            br_first_instr <= 1'b0;
        end else if (branch_taken) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ready0         <= 1'b1;
            ready1         <= 1'b1;
            even_q         <= empty_slot(NOP_OP);
            odd_q          <= empty_slot(LNOP_OP);
            br_first_instr <= 1'b0;
        end else begin
            head           <= head + PW'(num_issue);
            tail           <= tail + PW'(num_push);
            count          <= count_nxt;
            ready0         <= count_nxt < CW'(DEPTH);
            ready1         <= count_nxt <= CW'(DEPTH-2);
            even_q         <= even_nxt;
            odd_q          <= odd_nxt;
            br_first_instr <= br_nxt;
        end
    end

    // Contents need no reset: count and the pointers define what is live.
    always_ff @(posedge clk) begin
        if (acc0) mem[tail]    <= in0;
        if (acc1) mem[tail_p1] <= in1;
    end

    assign valid_even   = even_q.valid;
    assign opcode_even  = even_q.op;
    assign addr_ra_even = even_q.ra;
    assign addr_rb_even = even_q.rb;
    assign addr_rc_even = even_q.rc;
    assign addr_rt_even = even_q.rt;
    assign imm_even     = even_q.imm;
    assign valid_odd    = odd_q.valid;
    assign opcode_odd   = odd_q.op;
    assign addr_ra_odd  = odd_q.ra;
    assign addr_rb_odd  = odd_q.rb;
    assign addr_rc_odd  = odd_q.rc;
    assign addr_rt_odd  = odd_q.rt;
    assign imm_odd      = odd_q.imm;
endmodule

// File: tb/tb_dual_issue_queue.sv
// Bench for dual_issue_queue: directed pinning cases then randomized traffic
// checked every cycle against a queue-based reference model.
module tb_dual_issue_queue;
    localparam int DEPTH = 4;
    localparam int OP_W  = 8;
    localparam int RA_W  = 7;
    localparam int IMM_W = 18;
    localparam int E_W   = 1 + OP_W + 4*RA_W + IMM_W;
    localparam int CW    = $clog2(DEPTH+1);

    localparam logic [7:0] NOP      = 8'h01;
    localparam logic [7:0] LNOP     = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h10;
    localparam logic [7:0] OP_LQD   = 8'h20;
    localparam logic [7:0] OP_BRASL = 8'h30;
    localparam logic [7:0] OP_MPYA  = 8'h40;
    localparam logic [7:0] OP_SHLQ  = 8'h50;

    logic             clk, reset;
    logic             push0_en, push1_en, stall, branch_taken;
    logic [E_W-1:0]   push0_data, push1_data;
    logic             ready0, ready1, valid_even, valid_odd, br_first_instr;
    logic [CW-1:0]    count;
    logic [OP_W-1:0]  opcode_even, opcode_odd;
    logic [RA_W-1:0]  addr_ra_even, addr_rb_even, addr_rc_even, addr_rt_even;
    logic [RA_W-1:0]  addr_ra_odd, addr_rb_odd, addr_rc_odd, addr_rt_odd;
    logic [IMM_W-1:0] imm_even, imm_odd;

    dual_issue_queue #(.DEPTH(DEPTH), .OP_W(OP_W), .RA_W(RA_W), .IMM_W(IMM_W),
                       .NOP_OP(NOP), .LNOP_OP(LNOP)) dut (
        .clk(clk), .reset(reset),
        .push0_en(push0_en), .push1_en(push1_en),
        .push0_data(push0_data), .push1_data(push1_data),
        .ready0(ready0), .ready1(ready1), .count(count),
        .stall(stall), .branch_taken(branch_taken),
        .valid_even(valid_even), .opcode_even(opcode_even),
        .addr_ra_even(addr_ra_even), .addr_rb_even(addr_rb_even),
        .addr_rc_even(addr_rc_even), .addr_rt_even(addr_rt_even), .imm_even(imm_even),
        .valid_odd(valid_odd), .opcode_odd(opcode_odd),
        .addr_ra_odd(addr_ra_odd), .addr_rb_odd(addr_rb_odd),
        .addr_rc_odd(addr_rc_odd), .addr_rt_odd(addr_rt_odd), .imm_odd(imm_odd),
        .br_first_instr(br_first_instr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [E_W-1:0] mq[$];
    logic [63:0]    exp_even, exp_odd;
    logic           exp_br, exp_r0, exp_r1;
    int             exp_count;

    function automatic logic [E_W-1:0] mk(input logic p, input logic [7:0] op,
        input logic [6:0] rt, input logic [6:0] ra, input logic [6:0] rb,
        input logic [6:0] rc, input logic [17:0] imm);
        return {p, op, rt, ra, rb, rc, imm};
    endfunction

    function automatic logic f_pipe(input logic [E_W-1:0] e);
        return e[E_W-1];
    endfunction
    function automatic logic [6:0] f_rt(input logic [E_W-1:0] e);
        return e[IMM_W+4*RA_W-1 -: RA_W];
    endfunction
    function automatic logic [6:0] f_ra(input logic [E_W-1:0] e);
        return e[IMM_W+3*RA_W-1 -: RA_W];
    endfunction
    function automatic logic [6:0] f_rb(input logic [E_W-1:0] e);
        return e[IMM_W+2*RA_W-1 -: RA_W];
    endfunction
    function automatic logic [6:0] f_rc(input logic [E_W-1:0] e);
        return e[IMM_W+RA_W-1 -: RA_W];
    endfunction

    // slot bundle {valid, opcode, ra, rb, rc, rt, imm}
    function automatic logic [63:0] slot_of(input logic [E_W-1:0] e);
        return {9'd0, 1'b1, e[E_W-2 -: OP_W], f_ra(e), f_rb(e), f_rc(e), f_rt(e), e[IMM_W-1:0]};
    endfunction
    function automatic logic [63:0] empty_of(input logic [7:0] op);
        return {9'd0, 1'b0, op, 46'd0};
    endfunction

    function automatic logic hazard(input logic [E_W-1:0] a, input logic [E_W-1:0] b);
`ifdef DUAL_ISSUE_RAW_CHECK_EN
        return (f_rt(a) != 7'd0) &&
               ((f_rt(a) == f_ra(b)) || (f_rt(a) == f_rb(b)) || (f_rt(a) == f_rc(b)));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        int             sz;
        bit             r0, r1, pair;
        logic [E_W-1:0] hd;
        exp_even = empty_of(NOP);
        exp_odd  = empty_of(LNOP);
        exp_br   = 1'b0;
        if (!reset || branch_taken) begin
            mq.delete();
        end else begin
            sz = mq.size();
            r0 = sz < DEPTH;
            r1 = sz <= DEPTH - 2;
            if (!stall && sz > 0) begin
                hd   = mq[0];
                pair = (sz >= 2) && (f_pipe(mq[1]) != f_pipe(hd)) && !hazard(hd, mq[1]);
                if (f_pipe(hd)) exp_odd = slot_of(hd); else exp_even = slot_of(hd);
                if (pair) begin
                    if (f_pipe(hd)) exp_even = slot_of(mq[1]); else exp_odd = slot_of(mq[1]);
                    exp_br = f_pipe(hd);
                    void'(mq.pop_front());
                end
                void'(mq.pop_front());
            end
            if (push0_en && r0) mq.push_back(push0_data);
            if (push0_en && push1_en && r1) mq.push_back(push1_data);
        end
        exp_count = mq.size();
        exp_r0    = exp_count < DEPTH;
        exp_r1    = exp_count <= DEPTH - 2;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("even_slot", {9'd0, valid_even, opcode_even, addr_ra_even, addr_rb_even,
              addr_rc_even, addr_rt_even, imm_even}, exp_even);
        check("odd_slot", {9'd0, valid_odd, opcode_odd, addr_ra_odd, addr_rb_odd,
              addr_rc_odd, addr_rt_odd, imm_odd}, exp_odd);
        check("br_first_instr", 64'(br_first_instr), 64'(exp_br));
        check("count", 64'(count), 64'(exp_count));
        check("ready0", 64'(ready0), 64'(exp_r0));
        check("ready1", 64'(ready1), 64'(exp_r1));
    endtask

    // driver: inputs are changed at the falling edge, checked #1 after rising
    task automatic do_cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic drive(input logic p0, input logic [E_W-1:0] d0, input logic p1,
                         input logic [E_W-1:0] d1, input logic st, input logic br);
        push0_en = p0; push0_data = d0; push1_en = p1; push1_data = d1;
        stall = st; branch_taken = br;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        do_cycle();
    endtask

    function automatic logic [E_W-1:0] rand_entry();
        return mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                  7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                  18'($urandom));
    endfunction

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        exp_even = empty_of(NOP); exp_odd = empty_of(LNOP);
        exp_br = 1'b0; exp_count = 0; exp_r0 = 1'b1; exp_r1 = 1'b1;

        // reset state
        do_cycle();
        do_cycle();
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready0", 64'(ready0), 64'd1);
        check("rst_ready1", 64'(ready1), 64'd1);
        check("rst_valid_even", 64'(valid_even), 64'd0);
        check("rst_valid_odd", 64'(valid_odd), 64'd0);
        check("rst_op_even", 64'(opcode_even), 64'(NOP));
        check("rst_op_odd", 64'(opcode_odd), 64'(LNOP));
        check("rst_rt_even", 64'(addr_rt_even), 64'd0);
        check("rst_rt_odd", 64'(addr_rt_odd), 64'd0);
        reset = 1'b1;
        idle();

        // even-first pair
        drive(1'b1, mk(1'b0, OP_ADD, 7'd3, 7'd1, 7'd2, 7'd0, 18'd0), 1'b1,
              mk(1'b1, OP_LQD, 7'd5, 7'd2, 7'd0, 7'd0, 18'h40), 1'b0, 1'b0);
        do_cycle();
        check("pair1_count_queued", 64'(count), 64'd2);
        idle();
        check("pair1_valid_even", 64'(valid_even), 64'd1);
        check("pair1_op_even", 64'(opcode_even), 64'(OP_ADD));
        check("pair1_rt_even", 64'(addr_rt_even), 64'd3);
        check("pair1_valid_odd", 64'(valid_odd), 64'd1);
        check("pair1_op_odd", 64'(opcode_odd), 64'(OP_LQD));
        check("pair1_rt_odd", 64'(addr_rt_odd), 64'd5);
        check("pair1_imm_odd", 64'(imm_odd), 64'h40);
        check("pair1_br", 64'(br_first_instr), 64'd0);
        check("pair1_count", 64'(count), 64'd0);

        // odd-first pair
        drive(1'b1, mk(1'b1, OP_BRASL, 7'd9, 7'd0, 7'd0, 7'd0, 18'h123), 1'b1,
              mk(1'b0, OP_MPYA, 7'd6, 7'd1, 7'd2, 7'd4, 18'd0), 1'b0, 1'b0);
        do_cycle();
        idle();
        check("pair2_br", 64'(br_first_instr), 64'd1);
        check("pair2_op_odd", 64'(opcode_odd), 64'(OP_BRASL));
        check("pair2_op_even", 64'(opcode_even), 64'(OP_MPYA));
        check("pair2_rt_even", 64'(addr_rt_even), 64'd6);

        // intra-pair RAW
        drive(1'b1, mk(1'b0, OP_ADD, 7'd3, 7'd1, 7'd2, 7'd0, 18'd0), 1'b1,
              mk(1'b1, OP_SHLQ, 7'd7, 7'd3, 7'd0, 7'd0, 18'd5), 1'b0, 1'b0);
        do_cycle();
        idle();
        check("raw_c1_valid_even", 64'(valid_even), 64'd1);
`ifdef DUAL_ISSUE_RAW_CHECK_EN
        check("raw_c1_valid_odd", 64'(valid_odd), 64'd0);
        check("raw_c1_op_odd", 64'(opcode_odd), 64'(LNOP));
        idle();
        check("raw_c2_valid_odd", 64'(valid_odd), 64'd1);
        check("raw_c2_op_odd", 64'(opcode_odd), 64'(OP_SHLQ));
        check("raw_c2_valid_even", 64'(valid_even), 64'd0);
`else
        check("raw_c1_valid_odd", 64'(valid_odd), 64'd1);
        check("raw_c1_op_odd", 64'(opcode_odd), 64'(OP_SHLQ));
        idle();
        check("raw_c2_valid_odd", 64'(valid_odd), 64'd0);
`endif

        // fill under stall, overflow push dropped, drain 2 then 2
        drive(1'b1, mk(1'b0, OP_ADD, 7'd0, 7'd1, 7'd1, 7'd0, 18'd1), 1'b1,
              mk(1'b1, OP_LQD, 7'd0, 7'd2, 7'd0, 7'd0, 18'd2), 1'b1, 1'b0);
        do_cycle();
        drive(1'b1, mk(1'b0, OP_ADD, 7'd0, 7'd3, 7'd3, 7'd0, 18'd3), 1'b1,
              mk(1'b1, OP_LQD, 7'd0, 7'd4, 7'd0, 7'd0, 18'd4), 1'b1, 1'b0);
        do_cycle();
        check("full_count", 64'(count), 64'd4);
        check("full_ready0", 64'(ready0), 64'd0);
        check("full_valid_even", 64'(valid_even), 64'd0);
        drive(1'b1, mk(1'b0, OP_MPYA, 7'd0, 7'd0, 7'd0, 7'd0, 18'd9), 1'b0, '0, 1'b1, 1'b0);
        do_cycle();
        check("drop_count", 64'(count), 64'd4);
        idle();
        check("drain1_valid_even", 64'(valid_even), 64'd1);
        check("drain1_valid_odd", 64'(valid_odd), 64'd1);
        check("drain1_count", 64'(count), 64'd2);
        idle();
        check("drain2_imm_even", 64'(imm_even), 64'd3);
        check("drain2_count", 64'(count), 64'd0);
        idle();
        check("drop_never_issues", 64'(valid_even), 64'd0);

        // flush with 3 queued and a simultaneous push
        drive(1'b1, mk(1'b0, OP_ADD, 7'd0, 7'd1, 7'd0, 7'd0, 18'd0), 1'b1,
              mk(1'b1, OP_LQD, 7'd0, 7'd1, 7'd0, 7'd0, 18'd0), 1'b1, 1'b0);
        do_cycle();
        drive(1'b1, mk(1'b0, OP_ADD, 7'd0, 7'd2, 7'd0, 7'd0, 18'd0), 1'b0, '0, 1'b1, 1'b0);
        do_cycle();
        check("pre_flush_count", 64'(count), 64'd3);
        drive(1'b1, mk(1'b0, OP_MPYA, 7'd1, 7'd0, 7'd0, 7'd0, 18'd7), 1'b1,
              mk(1'b1, OP_BRASL, 7'd1, 7'd0, 7'd0, 7'd0, 18'd7), 1'b1, 1'b1);
        do_cycle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_op_even", 64'(opcode_even), 64'(NOP));
        check("flush_op_odd", 64'(opcode_odd), 64'(LNOP));
        idle();
        check("flush_after_valid_even", 64'(valid_even), 64'd0);
        check("flush_after_valid_odd", 64'(valid_odd), 64'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            drive(1'($urandom_range(0, 2) != 0), rand_entry(),
                  1'($urandom_range(0, 1)), rand_entry(),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0));
            do_cycle();
        end
        reset = 1'b1;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dual_issue_queue.md
# dual_issue_queue

Parametrised in-order instruction queue between decode and the SPU dual pipes (`spuMainModule`). Decode writes up to two instructions per cycle. The queue issues up to two per cycle from its head, one to the even pipe and one to the odd pipe, under pairing rules. It supports a configurable depth, empty-slot NOP/LNOP insertion, intra-pair RAW blocking, stall and branch flush, and it generates `br_first_instr`. It replaces the hand-sequenced even/odd stimulus used so far.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, ≥ 4.
- `OP_W`, INTERNAL_OPCODE_SIZE: opcode width.
- `RA_W`, REG_ADDR_WIDTH: register address width.
- `IMM_W`, IMM18: immediate field width. Narrower immediates sit right-aligned in this field.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `push0_en` in 1: write slot 0, the older instruction.
- `push1_en` in 1: write slot 1; ignored unless `push0_en` is high.
- `push0_data`, `push1_data` in 1+OP_W+4·RA_W+IMM_W: entry fields {pipe, opcode, rt, ra, rb, rc, imm}. `pipe` is 0 for even, 1 for odd.
- `ready0` out 1: at least one free entry.
- `ready1` out 1: at least two free entries.
- `count` out $clog2(DEPTH+1): current occupancy.
- `stall` in 1: suppress issue this cycle.
- `branch_taken` in 1: flush all queued instructions.
- `valid_even` out 1: even slot carries a real instruction.
- `opcode_even` out OP_W: even-slot opcode.
- `addr_ra_even`, `addr_rb_even`, `addr_rc_even`, `addr_rt_even` out RA_W each: even-slot register addresses.
- `imm_even` out IMM_W: even-slot immediate.
- `valid_odd` out 1: odd slot carries a real instruction.
- `opcode_odd` out OP_W: odd-slot opcode.
- `addr_ra_odd`, `addr_rb_odd`, `addr_rc_odd`, `addr_rt_odd` out RA_W each: odd-slot register addresses.
- `imm_odd` out IMM_W: odd-slot immediate.
- `br_first_instr` out 1: in the issued pair, the odd instruction is the older one.

## Operation
- Storage is a circular buffer with `head` and `tail` pointers, each log2(DEPTH) bits with natural wrap, plus `count`.
- Push, in the same edge:
  - `push0_en` with `ready0` high writes the entry at `tail`.
  - `push1_en` with `ready1` high additionally writes the entry at `tail+1`.
  - A push attempted while its ready is low is dropped; the queue state is unchanged by that slot.
- Issue decision, made combinationally from H = entry at `head` and N = entry at `head+1`:
  - If `stall`, or `count` is 0, nothing issues.
  - H always issues to its own pipe.
  - N also issues if all three hold: `count` ≥ 2; N.pipe ≠ H.pipe; and no RAW hazard (see Configuration).
  - `head` advances by the number issued, and `count` updates by pushes minus issues.
  - A push and an issue in the same edge are both honoured. `ready0` and `ready1` are computed from pre-edge `count`.
- Output slot content:
  - A slot with an instruction: its fields, with `valid_*` set to 1.
  - An empty slot: `opcode_even`=NOP or `opcode_odd`=LNOP, all addresses 0, `imm` 0, `valid`=0.
- `br_first_instr` = 1 only when a pair issues with H.pipe = 1 (odd instruction older). In every other case it is 0.
- Flush: `branch_taken` high at an edge does all of the following:
  - Sets `head`=`tail`=`count`=0.
  - Drops any push in that edge.
  - Drives both output slots to NOP/LNOP.
  - `branch_taken` has priority over `stall` and over push.
- Reset (asynchronous assert, while low):
  - Pointers and `count` are 0.
  - `valid_*`=0, opcodes are NOP/LNOP, all addresses and immediates are 0, `br_first_instr`=0.
  - `ready0`=`ready1`=1.
  - Reset asserted mid-operation discards all queue contents.

## Timing
- All issue outputs are registered.
- An instruction pushed at edge k, into an empty queue with no stall, appears on the outputs after edge k+1. Push-to-issue latency is 1 cycle.
- Throughput: at most 2 instructions issued per cycle, and at most 2 accepted per cycle.
- `count`, `ready0` and `ready1` are registered and reflect the state after the last edge.
- Flush takes effect at the edge where `branch_taken` is sampled. The outputs after that edge are NOP/LNOP.
- Under `stall` the queue is held and the outputs after the edge are NOP/LNOP. Instructions are never re-issued.

## Configuration
- `DUAL_ISSUE_RAW_CHECK_EN` defined:
  - N is blocked from pairing when H writes a register N reads: H.rt ≠ 0 and H.rt equals N.ra, N.rb or N.rc.
  - N then issues alone in a later cycle.
- Not defined:
  - Pairing depends only on the pipe bits and `count`. Hazards are left to software scheduling.

## Test plan
- Reset with `reset`=0, then release:
  - `count`=0, `ready0`=`ready1`=1, `valid_even`=`valid_odd`=0.
  - Opcodes are NOP/LNOP and `addr_rt_*`=0.
- Push pair {even ADD_WORD rt=3 ra=1 rb=2, odd LOAD_QUADWORD_D rt=5 ra=2}:
  - The next cycle issues both; `br_first_instr`=0; `count` returns to 0.
- Push pair {odd BRANCH_RELATIVE_AND_SET_LINK, even MULTIPLY_AND_ADD rt=6}:
  - Both issue together, with `br_first_instr`=1.
- With the macro defined, push {even ADD_WORD rt=3, odd SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE ra=3}:
  - The even instruction issues in cycle 1 with LNOP in the odd slot; the odd instruction issues in cycle 2.
  - Without the macro, both issue in cycle 1.
- DEPTH=4, `stall`=1, push 2 pairs:
  - `count`=4, `ready0`=0; a fifth push is dropped.
  - Release the stall: issue is 2, then 2 (if the pipes alternate).
- With 3 entries queued, assert `branch_taken` together with a push:
  - `count`=0 after the edge; both slots show NOP/LNOP; the pushed entry never issues.
